// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end: owns the PC, issues one I-cache request at a time,
// holds the returned instruction for IF/ID and applies flush/branch redirects.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned DATA_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [5:0]        stall,
    input  logic              flush,
    input  logic [ADDR_W-1:0] new_pc,
    input  logic              branch_flag,
    input  logic [ADDR_W-1:0] branch_target,
    output logic              icache_req,
    output logic [ADDR_W-1:0] icache_addr,
    input  logic              icache_ready,
    input  logic              icache_rvalid,
    input  logic [DATA_W-1:0] icache_rdata,
    output logic [ADDR_W-1:0] if_pc,
    output logic [DATA_W-1:0] if_inst,
    output logic              if_valid,
    output logic              stallreq_if
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        HOLD
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic                discard_q, discard_d;
    logic [ADDR_W-1:0]   if_pc_q, if_pc_d;
    logic [DATA_W-1:0]   if_inst_q, if_inst_d;
    logic                if_valid_q, if_valid_d;

    logic                redirect;
    logic [ADDR_W-1:0]   target;
    logic                unused_stall;

    assign unused_stall = ^{stall[5:2], stall[0]};

    // Flush has priority over a branch from ID.
    assign redirect = flush | branch_flag;
    assign target   = flush ? new_pc : branch_target;

    assign icache_req  = (state_q == REQ);
    assign icache_addr = pc_q;
    assign stallreq_if = (state_q == REQ) || (state_q == WAIT);
    assign if_pc       = if_pc_q;
    assign if_inst     = if_inst_q;
    assign if_valid    = if_valid_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            pc_q       <= ADDR_W'(RESET_PC);
            discard_q  <= 1'b0;
            if_pc_q    <= '0;
            if_inst_q  <= '0;
            if_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            discard_q  <= discard_d;
            if_pc_q    <= if_pc_d;
            if_inst_q  <= if_inst_d;
            if_valid_q <= if_valid_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        discard_d  = discard_q;
        if_pc_d    = if_pc_q;
        if_inst_d  = if_inst_q;
        if_valid_d = if_valid_q;

        unique case (state_q)
            IDLE: begin
                state_d = REQ;
                if (redirect) pc_d = target;
            end

            REQ: begin
                if (redirect) pc_d = target;
                // A redirect coinciding with acceptance leaves the old address in flight.
                if (icache_ready) begin
                    state_d   = WAIT;
                    discard_d = redirect;
                end
            end

            WAIT: begin
                if (icache_rvalid) begin
                    discard_d = 1'b0;
                    if (redirect) begin
                        pc_d    = target;
                        state_d = REQ;
                    end else if (discard_q) begin
                        state_d = REQ;
                    end else begin
                        if_pc_d    = pc_q;
                        if_inst_d  = icache_rdata;
                        if_valid_d = 1'b1;
                        state_d    = HOLD;
                    end
                end else if (redirect) begin
                    pc_d      = target;
                    discard_d = 1'b1;
                end
            end

            HOLD: begin
                if (redirect || !stall[1]) begin
                    pc_d       = redirect ? target : pc_q + ADDR_W'(4);
                    if_pc_d    = '0;
                    if_inst_d  = '0;
                    if_valid_d = 1'b0;
                    state_d    = REQ;
                end
            end

            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed scenarios followed by random traffic, all
// checked against a transaction-level model of the fetch front end.
module tb_if_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        branch_flag;
    logic [31:0] branch_target;
    logic        icache_req;
    logic [31:0] icache_addr;
    logic        icache_ready;
    logic        icache_rvalid;
    logic [31:0] icache_rdata;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        if_valid;
    logic        stallreq_if;

    int checks = 0;
    int errors = 0;

    if_fetch_unit #(
        .RESET_PC(32'h0000_0000),
        .ADDR_W  (32),
        .DATA_W  (32)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .flush        (flush),
        .new_pc       (new_pc),
        .branch_flag  (branch_flag),
        .branch_target(branch_target),
        .icache_req   (icache_req),
        .icache_addr  (icache_addr),
        .icache_ready (icache_ready),
        .icache_rvalid(icache_rvalid),
        .icache_rdata (icache_rdata),
        .if_pc        (if_pc),
        .if_inst      (if_inst),
        .if_valid     (if_valid),
        .stallreq_if  (stallreq_if)
    );

    always #5 clk = ~clk;

    // Model: a started flag, the PC, the requests outstanding at the cache
    // (each tagged live or stale) and the instruction presented to IF/ID.
    bit          m_started;
    logic [31:0] m_pc;
    bit          m_out[$];
    bit          m_hv;
    logic [31:0] m_hpc;
    logic [31:0] m_hinst;

    function automatic void model_reset();
        m_started = 1'b0;
        m_pc      = 32'h0;
        m_out.delete();
        m_hv      = 1'b0;
        m_hpc     = 32'h0;
        m_hinst   = 32'h0;
    endfunction

    function automatic void model_update();
        bit          redir;
        logic [31:0] tgt;
        bit          live;
        redir = flush || branch_flag;
        tgt   = flush ? new_pc : branch_target;
        if (!m_started) begin
            m_started = 1'b1;
            if (redir) m_pc = tgt;
        end else if (m_hv) begin
            if (redir || !stall[1]) begin
                m_pc = redir ? tgt : m_pc + 32'd4;
                m_hv = 1'b0;
            end
        end else if (m_out.size() == 0) begin
            if (icache_ready) m_out.push_back(!redir);
            if (redir) m_pc = tgt;
        end else if (icache_rvalid) begin
            live = m_out.pop_front();
            if (redir) m_pc = tgt;
            else if (live) begin
                m_hv    = 1'b1;
                m_hpc   = m_pc;
                m_hinst = icache_rdata;
            end
        end else if (redir) begin
            m_out[0] = 1'b0;
            m_pc     = tgt;
        end
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        bit exp_req;
        exp_req = m_started && !m_hv && (m_out.size() == 0);
        chk("if_valid", {31'b0, if_valid}, {31'b0, m_hv});
        chk("if_pc", if_pc, m_hv ? m_hpc : 32'h0);
        chk("if_inst", if_inst, m_hv ? m_hinst : 32'h0);
        chk("icache_req", {31'b0, icache_req}, {31'b0, exp_req});
        chk("stallreq_if", {31'b0, stallreq_if}, {31'b0, m_started && !m_hv});
        if (exp_req) chk("icache_addr", icache_addr, m_pc);
    endtask

    // Called at a negedge: check, drive, clock, advance the model.
    task automatic step(input bit rdy, input bit rv, input logic [31:0] rd,
                        input logic [5:0] st, input bit fl, input logic [31:0] np,
                        input bit br, input logic [31:0] bt);
        check_outputs();
        icache_ready  = rdy;
        icache_rvalid = rv;
        icache_rdata  = rd;
        stall         = st;
        flush         = fl;
        new_pc        = np;
        branch_flag   = br;
        branch_target = bt;
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_valid"}, {31'b0, if_valid}, 32'h0);
        chk({tag, "_pc"}, if_pc, 32'h0);
        chk({tag, "_inst"}, if_inst, 32'h0);
        chk({tag, "_req"}, {31'b0, icache_req}, 32'h0);
        chk({tag, "_stallreq"}, {31'b0, stallreq_if}, 32'h0);
    endtask

    initial begin
        logic [31:0] tgt;
        bit          rv;

        rst = 1'b0;
        stall = '0; flush = 1'b0; new_pc = '0; branch_flag = 1'b0; branch_target = '0;
        icache_ready = 1'b0; icache_rvalid = 1'b0; icache_rdata = '0;
        model_reset();
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst = 1'b1;

        // Basic fetch at RESET_PC, then next sequential request.
        step(1, 0, 0, 0, 0, 0, 0, 0);
        chk("first_addr", icache_addr, 32'h0);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 32'h0000_0093, 0, 0, 0, 0, 0);
        chk("t1_inst", if_inst, 32'h0000_0093);
        chk("t1_pc", if_pc, 32'h0);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        chk("t1_next_addr", icache_addr, 32'h4);

        // Hold under stall[1] with a spurious rvalid thrown in.
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 32'h1111_2222, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(1, (i == 2), 32'hBAD0_0000, 6'b000010, 0, 0, 0, 0);
        chk("t2_held_pc", if_pc, 32'h4);
        chk("t2_no_req", {31'b0, icache_req}, 32'h0);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        chk("t2_next_addr", icache_addr, 32'h8);

        // Branch while waiting: the in-flight response is dropped.
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 1, 32'h100);
        step(0, 1, 32'hDEAD_BEEF, 0, 0, 0, 0, 0);
        chk("t3_addr", icache_addr, 32'h100);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 32'h0000_0113, 0, 0, 0, 0, 0);
        chk("t3_pc", if_pc, 32'h100);

        // Flush and branch together in HOLD: flush wins.
        step(0, 0, 0, 6'b000010, 1, 32'h200, 1, 32'h300);
        chk("t4_valid", {31'b0, if_valid}, 32'h0);
        chk("t4_addr", icache_addr, 32'h200);

        // Back-pressure with a branch while the request is pending.
        step(0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 1, 32'h40);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        chk("t5_req", {31'b0, icache_req}, 32'h1);
        chk("t5_addr", icache_addr, 32'h40);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 32'h0000_0040, 0, 0, 0, 0, 0);
        chk("t5_pc", if_pc, 32'h40);
        step(1, 0, 0, 0, 0, 0, 0, 0);

        // Asynchronous reset while a request is outstanding; stale rvalid follows.
        step(1, 0, 0, 0, 0, 0, 0, 0);
        #2 rst = 1'b0;
        #1 check_zero("midreset");
        model_reset();
        @(posedge clk);
        @(negedge clk);
        check_zero("midreset_held");
        rst = 1'b1;
        step(0, 1, 32'hBAD0_BAD0, 0, 0, 0, 0, 0);
        step(0, 1, 32'hBAD0_BAD1, 0, 0, 0, 0, 0);
        chk("t6_restart_addr", icache_addr, 32'h0);

        // Random traffic, including targets that exercise PC wrap-around.
        for (int n = 0; n < 3000; n++) begin
            tgt = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : ($urandom() & 32'hFFFF_FFFC);
            rv  = (m_out.size() > 0) ? bit'($urandom_range(0, 1)) : ($urandom_range(0, 19) == 0);
            step(($urandom_range(0, 9) < 7), rv, $urandom(),
                 6'($urandom()) & (($urandom_range(0, 9) < 3) ? 6'h3F : 6'h3D),
                 ($urandom_range(0, 24) == 0), tgt,
                 ($urandom_range(0, 15) == 0), tgt ^ 32'h0000_0010);
        end
        check_outputs();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction-fetch front end that produces the if_pc / if_inst pair consumed by the IF/ID pipeline register.
- Owns the PC and issues one request at a time to the 2-way set-associative instruction cache.
- Holds the returned instruction until the pipeline accepts it, and raises a stall request to ctrl while no instruction is ready.
- Applies flush redirects (ctrl) and branch redirects (ID), discarding any stale in-flight cache response.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
ADDR_W, 32, PC / cache address width
DATA_W, 32, instruction width

Ports:
clk  input  1  clock; all state updates on posedge
rst  input  1  asynchronous, active-low reset (0 = reset)
stall  input  6  ctrl stall vector; bit1 = IF/ID hold (1 = Stop)
flush  input  1  ctrl flush; redirect to new_pc
new_pc  input  ADDR_W  flush target
branch_flag  input  1  ID branch taken, one-cycle pulse
branch_target  input  ADDR_W  branch target
icache_req  output  1  fetch request valid
icache_addr  output  ADDR_W  fetch address
icache_ready  input  1  cache accepts request this cycle
icache_rvalid  input  1  instruction return valid
icache_rdata  input  DATA_W  returned instruction
if_pc  output  ADDR_W  PC of presented instruction; 0 when not valid
if_inst  output  DATA_W  presented instruction; 0 (bubble) when not valid
if_valid  output  1  if_pc / if_inst hold a live instruction
stallreq_if  output  1  to ctrl: no instruction ready

Behaviour:
- Reset (rst=0, async):
  - pc=RESET_PC, state=IDLE, discard=0.
  - if_pc=0, if_inst=0, if_valid=0, icache_req=0.
  - stallreq_if=0 while in reset.
- State machine:
  - IDLE -> REQ on the first clock after reset release.
  - REQ:
    - Drives icache_req=1, icache_addr=pc.
    - The cache samples the address only on cycles where icache_req && icache_ready are both 1 (accepted).
    - On accept -> WAIT.
    - Until accepted, icache_addr tracks pc and may change on a redirect.
  - WAIT:
    - icache_req=0. Exactly one request is outstanding.
    - On icache_rvalid with discard=0: latch if_inst=icache_rdata, if_pc=pc, if_valid=1 -> HOLD.
    - On icache_rvalid with discard=1: drop the data, clear discard -> REQ.
  - HOLD:
    - Outputs held stable.
    - At a posedge with stall[1]=0 the instruction is consumed: pc<=pc+4 (wraps modulo 2^ADDR_W), if_valid<=0, if_pc/if_inst<=0 -> REQ.
    - stall[1]=1: remain in HOLD.
- stallreq_if = 1 in REQ and WAIT, 0 in HOLD and IDLE. It is combinational from state.
- Fetch latency: minimum 3 cycles from entering REQ to HOLD (REQ accept, WAIT with rvalid, HOLD visible).
- Redirects:
  - Priority is flush over branch_flag; both beat normal sequencing.
  - Target = new_pc on flush, branch_target on branch. pc<=target in all cases.
  - HOLD: if_valid/if_pc/if_inst cleared -> REQ. The redirect overrides consumption even when stall[1]=0.
  - WAIT, no rvalid this cycle: discard<=1, stay WAIT.
  - WAIT, rvalid in the same cycle: response dropped -> REQ with the new pc. discard stays 0.
  - REQ, icache_ready=1 in the same cycle: old address accepted -> WAIT with discard=1.
  - REQ, icache_ready=0: stay REQ; the address becomes target next cycle.
  - IDLE: pc<=target, still -> REQ.
- Redirects are taken regardless of stall.
- Spurious icache_rvalid in IDLE, REQ or HOLD is ignored.
- Reset asserted mid-transaction returns to the reset state immediately. The in-flight response after reset release must be ignored: it arrives in REQ and is dropped.

Test Plan:
- Reset release with RESET_PC=0, cache ready=1, rvalid 1 cycle after accept with rdata=32'h0000_0093, stall=0:
  - icache_addr=0, then if_valid=1, if_pc=0, if_inst=32'h93 for 1 cycle.
  - Next request addr=4.
  - stallreq_if high in REQ/WAIT only.
- Hold under stall: in HOLD with stall[1]=1 for 5 cycles -> if_pc/if_inst unchanged, no new icache_req, pc advances to +4 only after stall[1]=0.
- Branch in WAIT: request addr=8 accepted, branch_flag with target=32'h100 before rvalid -> that response is dropped, next icache_addr=32'h100, presented if_pc=32'h100.
- Simultaneous flush and branch in HOLD with new_pc=32'h200, branch_target=32'h300 -> if_valid drops next cycle, next icache_addr=32'h200.
- Back-pressure: icache_ready=0 for 4 cycles, branch to 32'h40 in cycle 2 -> icache_req held high throughout, address switches to 32'h40, single accept at 32'h40, no discard.
- Async reset asserted in WAIT, released, then the stale rvalid arrives -> outputs 0 during reset, stale data not presented, fetch restarts at RESET_PC.
